fifo_wr_arbiter: RTL and testbench

Write-side arbiter and sequencer for the asynchronous FIFO. It shares the single FIFO write port (`w_en`/`data_in`) among `NUM_REQ` producers using round-robin bursts of at most `MAX_BURST` beats. It honours `full` so the FIFO never sees a write while full, and counts FIFO `write_error` pulses. It sits entirely in the write-clock domain, between the producers and the FIFO write port.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Index/counter width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after
// 'last', wrapping around, via a double-width masked priority encode.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               any,
   output logic [IDX_W-1:0]   idx
);

   logic [2*NUM_REQ-1:0] dbl;

   // Lower copy keeps only requesters above 'last'; upper copy is the wrap.
   always_comb begin
      dbl = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         dbl[i]         = req[i] && (i > int'(last));
         dbl[NUM_REQ+i] = req[i];
      end
   end

   // Scan downward so the lowest set position wins.
   always_comb begin
      any = |req;
      idx = '0;
      for (int p = 2*NUM_REQ-1; p >= 0; p--) begin
         if (dbl[p]) begin
            idx = (p >= NUM_REQ) ? IDX_W'(p - NUM_REQ) : IDX_W'(p);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NUM_REQ
// producers; never writes while full and counts overflow pulses.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int ERR_W      = 16,
   localparam int IDX_W     = clog2_min1(NUM_REQ)
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          w_en,
   output logic [DATA_WIDTH-1:0]         data_in,
   input  logic                          full,
   input  logic                          write_error,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          busy,
   output logic [ERR_W-1:0]              err_count
);

   localparam int BEAT_W = clog2_min1(MAX_BURST);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [ERR_W-1:0]    err_count_q, err_count_d;

   logic                pick_any;
   logic [IDX_W-1:0]    pick_idx;
   logic                owner_valid;
   logic [DATA_WIDTH-1:0] owner_data;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req  (req_valid),
      .last (last_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   always_comb begin
      owner_valid = 1'b0;
      owner_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == IDX_W'(i)) begin
            owner_valid = req_valid[i];
            owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      req_ready  = '0;
      w_en       = 1'b0;
      data_in    = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               owner_d    = pick_idx;
               last_d     = pick_idx;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               req_ready[i] = (owner_q == IDX_W'(i)) && !full;
            end
            w_en    = owner_valid && !full;
            data_in = owner_data;
            if (w_en) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
               end
            end else if (!owner_valid && !full) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_count_d = err_count_q;
      if (write_error && !(&err_count_q)) begin
         err_count_d = err_count_q + ERR_W'(1);
      end
   end

   // last resets to the top index so requester 0 wins the first pick.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         last_q      <= IDX_W'(NUM_REQ - 1);
         beat_cnt_q  <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         beat_cnt_q  <= beat_cnt_d;
         err_count_q <= err_count_d;
      end
   end

   assign grant_id  = owner_q;
   assign busy      = (state_q == BURST);
   assign err_count = err_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 requesters, 4-beat bursts).
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int EW = 4;

   logic             wclk = 1'b0;
   logic             wrst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic             w_en;
   logic [DW-1:0]    data_in;
   logic             full;
   logic             write_error;
   logic [1:0]       grant_id;
   logic             busy;
   logic [EW-1:0]    err_count;

   int n_tests = 0;
   int n_fail  = 0;

   int single_we[10]   = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
   int single_busy[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
   int bp_full[10]     = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
   int bp_we[10]       = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
   int bp_rdy[10]      = '{0, 2, 2, 0, 0, 0, 2, 2, 0, 0};

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB),
      .ERR_W      (EW)
   ) dut (
      .wclk        (wclk),
      .wrst_n      (wrst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .w_en        (w_en),
      .data_in     (data_in),
      .full        (full),
      .write_error (write_error),
      .grant_id    (grant_id),
      .busy        (busy),
      .err_count   (err_count)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      wrst_n      = 1'b0;
      req_valid   = '0;
      req_data    = '0;
      full        = 1'b0;
      write_error = 1'b0;
      step();
      step();
      wrst_n = 1'b1;
   endtask

   initial begin
      int idx;
      int wcnt;
      int g;
      int nwr;

      // Reset held with random inputs
      wrst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         req_valid   = NR'($urandom);
         req_data    = $urandom;
         full        = 1'($urandom_range(0, 1));
         write_error = 1'($urandom_range(0, 1));
         #1;
         check("rst_wen", w_en, 0);
         check("rst_ready", req_ready, 0);
         check("rst_data", data_in, 0);
         check("rst_grant", grant_id, 0);
         check("rst_busy", busy, 0);
         check("rst_err", err_count, 0);
         step();
      end

      // Single requester 2 streaming 0x20..0x25
      do_reset();
      idx  = 0;
      wcnt = 0;
      for (int c = 0; c < 10; c++) begin
         req_valid = (idx < 6) ? 4'b0100 : 4'b0000;
         req_data  = '0;
         req_data[2*DW +: DW] = DW'(8'h20 + idx);
         #1;
         check("single_wen", w_en, single_we[c]);
         check("single_busy", busy, single_busy[c]);
         if (single_we[c] != 0) begin
            check("single_data", data_in, 8'h20 + wcnt);
            check("single_grant", grant_id, 2);
            wcnt++;
         end
         if (req_valid[2] && req_ready[2]) idx++;
         step();
      end
      check("single_count", idx, 6);

      // All four requesters continuously valid
      do_reset();
      req_valid = 4'hF;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int c = 0; c < 25; c++) begin
         #1;
         check("all_wen", w_en, (c % 5 != 0) ? 1 : 0);
         if (c % 5 != 0) begin
            g = (c / 5) % 4;
            check("all_grant", grant_id, g);
            check("all_data", data_in, 8'hA0 + g);
            check("all_ready", req_ready, 1 << g);
         end
         step();
      end

      // Back-pressure: full for 3 cycles after beat 2
      do_reset();
      idx = 0;
      nwr = 0;
      for (int c = 0; c < 10; c++) begin
         req_valid = (idx < 4) ? 4'b0010 : 4'b0000;
         req_data  = '0;
         req_data[1*DW +: DW] = DW'(8'h10 + idx);
         full = 1'(bp_full[c]);
         #1;
         check("bp_wen", w_en, bp_we[c]);
         check("bp_ready", req_ready, bp_rdy[c]);
         if (w_en) begin
            check("bp_data", data_in, 8'h10 + nwr);
            nwr++;
         end
         if (req_valid[1] && req_ready[1]) idx++;
         step();
      end
      full = 1'b0;
      check("bp_writes", nwr, 4);
      check("bp_consumed", idx, 4);

      // Error counting saturates at 15, writes undisturbed
      do_reset();
      req_valid = 4'b0001;
      req_data  = '0;
      req_data[0 +: DW] = 8'h55;
      for (int c = 0; c < 40; c++) begin
         write_error = (c % 2 == 0);
         #1;
         check("err_wen", w_en, (c % 5 != 0) ? 1 : 0);
         if (c == 10) check("err_mid", err_count, 5);
         step();
      end
      write_error = 1'b0;
      #1;
      check("err_sat", err_count, 15);

      // Reset in the middle of a req 3 burst
      do_reset();
      req_valid = 4'b1000;
      req_data  = '0;
      req_data[3*DW +: DW] = 8'h3C;
      #1;
      check("mid_idle_wen", w_en, 0);
      step();
      #1;
      check("mid_beat1_wen", w_en, 1);
      check("mid_beat1_grant", grant_id, 3);
      step();
      #1;
      check("mid_beat2_wen", w_en, 1);
      wrst_n = 1'b0;
      #1;
      check("mid_rst_wen", w_en, 0);
      check("mid_rst_ready", req_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_grant", grant_id, 0);
      step();
      wrst_n    = 1'b1;
      req_valid = 4'b1001;
      req_data[0 +: DW] = 8'h0C;
      #1;
      check("post_idle_wen", w_en, 0);
      step();
      #1;
      check("post_grant", grant_id, 0);
      check("post_wen", w_en, 1);
      check("post_data", data_in, 8'h0C);
      check("post_ready", req_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
